// File: rtl/pool_relu_stream.sv
// Streaming 2x2/stride-2 signed max-pool with optional ReLU over an HWC byte stream.
// Emits pooled bytes in HWC order together with their linear address in the pooled map.
module pool_relu_stream #(
  parameter int DIM_IN = 32,
  parameter int CH     = 32,
  parameter int RELU   = 1,
  parameter int ADDR_W = 16
)(
  input  logic              clk,
  input  logic              nreset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [7:0]        in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [7:0]        out_data,
  output logic [ADDR_W-1:0] out_addr,
  output logic              frame_done
);

  localparam int HALF   = DIM_IN / 2;
  localparam int CH_W   = (CH > 1) ? $clog2(CH) : 1;
  localparam int POS_W  = $clog2(DIM_IN);
  localparam int LINE_N = HALF * CH;
  localparam int LINE_W = (LINE_N > 1) ? $clog2(LINE_N) : 1;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(HALF * HALF * CH - 1);

  logic              nreset_q;
  logic [CH_W-1:0]   ch;
  logic [POS_W-1:0]  col, row;
  logic signed [7:0] pair [CH];
  logic signed [7:0] line [LINE_N];

  logic              accept, produce;
  logic              ch_last, col_last, row_last;
  logic [LINE_W-1:0] line_idx;
  logic signed [7:0] x, pair_max, win_max, pooled;
  logic [ADDR_W-1:0] addr_nxt;

  assign in_ready = nreset_q && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;
  // The bottom-right beat of each window completes it.
  assign produce  = accept && col[0] && row[0];

  assign ch_last  = (ch  == CH_W'(CH - 1));
  assign col_last = (col == POS_W'(DIM_IN - 1));
  assign row_last = (row == POS_W'(DIM_IN - 1));

  assign x        = in_data;
  assign line_idx = LINE_W'(int'(col >> 1) * CH + int'(ch));
  assign pair_max = (pair[ch] > x) ? pair[ch] : x;
  assign win_max  = (line[line_idx] > pair_max) ? line[line_idx] : pair_max;
  assign pooled   = (RELU != 0 && win_max < 0) ? 8'sd0 : win_max;
  assign addr_nxt = ADDR_W'((int'(row >> 1) * HALF + int'(col >> 1)) * CH + int'(ch));

  assign frame_done = out_valid && out_ready && (out_addr == LAST_ADDR);

  always_ff @(posedge clk) begin
    nreset_q <= nreset;
  end

  always_ff @(posedge clk) begin
    if (!nreset) begin
      ch  <= '0;
      col <= '0;
      row <= '0;
    end else if (accept) begin
      if (ch_last) begin
        ch <= '0;
        if (col_last) begin
          col <= '0;
          row <= row_last ? '0 : row + 1'b1;
        end else begin
          col <= col + 1'b1;
        end
      end else begin
        ch <= ch + 1'b1;
      end
    end
  end

  // Window state is left uncleared; every window rewrites it before it is read.
  always_ff @(posedge clk) begin
    if (accept) begin
      if (!col[0])      pair[ch]       <= x;
      else if (!row[0]) line[line_idx] <= pair_max;
    end
  end

  always_ff @(posedge clk) begin
    if (!nreset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_addr  <= '0;
    end else if (produce) begin
      out_valid <= 1'b1;
      out_data  <= pooled;
      out_addr  <= addr_nxt;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pool_relu_stream.sv
// Randomized bench for pool_relu_stream: three instances (4x4x2 ReLU, 4x4x2 no ReLU,
// 16x16x8 ReLU) checked against a window-level max-pool model over whole frames.
module tb_pool_relu_stream;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [2:0]       nreset, in_valid, out_ready;
  logic [2:0]       in_ready, out_valid, frame_done;
  logic [2:0][7:0]  in_data, out_data;
  logic [2:0][15:0] out_addr;

  pool_relu_stream #(.DIM_IN(4), .CH(2), .RELU(1), .ADDR_W(16)) u_dut0 (
    .clk(clk), .nreset(nreset[0]), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .in_data(in_data[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
    .out_data(out_data[0]), .out_addr(out_addr[0]), .frame_done(frame_done[0]));

  pool_relu_stream #(.DIM_IN(4), .CH(2), .RELU(0), .ADDR_W(16)) u_dut1 (
    .clk(clk), .nreset(nreset[1]), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .in_data(in_data[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
    .out_data(out_data[1]), .out_addr(out_addr[1]), .frame_done(frame_done[1]));

  pool_relu_stream #(.DIM_IN(16), .CH(8), .RELU(1), .ADDR_W(16)) u_dut2 (
    .clk(clk), .nreset(nreset[2]), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
    .in_data(in_data[2]), .out_valid(out_valid[2]), .out_ready(out_ready[2]),
    .out_data(out_data[2]), .out_addr(out_addr[2]), .frame_done(frame_done[2]));

  int n_cmp = 0;
  int n_bad = 0;
  logic [7:0] in_q[$];
  int exp_d[$];
  int exp_a[$];
  int ramp_exp[8] = '{10, 11, 14, 15, 26, 27, 30, 31};

  function automatic int dim_of(input int k);  return (k == 2) ? 16 : 4; endfunction
  function automatic int ch_of(input int k);   return (k == 2) ? 8 : 2;  endfunction
  function automatic int relu_of(input int k); return (k == 1) ? 0 : 1;  endfunction

  task automatic chk(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference: each output is the max of its 2x2 spatial window for one channel.
  task automatic model(input int k);
    int d, c, fsz, v, m;
    d = dim_of(k); c = ch_of(k); fsz = d * d * c;
    exp_d = {}; exp_a = {};
    for (int f = 0; f < in_q.size() / fsz; f++)
      for (int pr = 0; pr < d / 2; pr++)
        for (int pc = 0; pc < d / 2; pc++)
          for (int cc = 0; cc < c; cc++) begin
            m = -1000;
            for (int dr = 0; dr < 2; dr++)
              for (int dc = 0; dc < 2; dc++) begin
                v = $signed(in_q[f * fsz + ((2 * pr + dr) * d + 2 * pc + dc) * c + cc]);
                if (v > m) m = v;
              end
            if (relu_of(k) != 0 && m < 0) m = 0;
            exp_d.push_back(m);
            exp_a.push_back((pr * (d / 2) + pc) * c + cc);
          end
  endtask

  task automatic gen_rand(input int k, input int nframes);
    in_q = {};
    for (int i = 0; i < nframes * dim_of(k) * dim_of(k) * ch_of(k); i++)
      in_q.push_back(8'($urandom_range(0, 255)));
  endtask

  task automatic gen_ramp();
    in_q = {};
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        for (int h = 0; h < 2; h++) in_q.push_back(8'(r * 8 + c * 2 + h));
    exp_d = {}; exp_a = {};
    for (int i = 0; i < 8; i++) begin
      exp_d.push_back(ramp_exp[i]);
      exp_a.push_back(i);
    end
  endtask

  // All -5 except a single -3 at a random position of every window.
  task automatic gen_neg(input int k);
    int d, c;
    d = dim_of(k); c = ch_of(k);
    in_q = {};
    for (int i = 0; i < d * d * c; i++) in_q.push_back(8'hFB);
    for (int pr = 0; pr < d / 2; pr++)
      for (int pc = 0; pc < d / 2; pc++)
        for (int cc = 0; cc < c; cc++)
          in_q[((2 * pr + $urandom_range(0, 1)) * d + 2 * pc + $urandom_range(0, 1)) * c + cc] = 8'hFD;
  endtask

  // Streams in_q into instance k and checks every accepted output against exp_d/exp_a.
  task automatic run(input int k, input int bub, input bit rnd_rdy, input bit stall3);
    int bi, cyc, stall, budget, fd, nfd_exp, last, gd;
    bi = 0; cyc = 0; fd = 0; nfd_exp = 0;
    stall  = stall3 ? 3 : 0;
    budget = 40 * in_q.size() + 200;
    last   = dim_of(k) * dim_of(k) / 4 * ch_of(k) - 1;
    foreach (exp_a[i]) if (exp_a[i] == last) nfd_exp++;
    while ((bi < in_q.size() || exp_d.size() > 0) && cyc < budget) begin
      out_ready[k] = rnd_rdy ? ($urandom_range(0, 3) != 0) : 1'b1;
      if (stall > 0 && out_valid[k]) out_ready[k] = 1'b0;
      if (bi < in_q.size() && $urandom_range(0, 99) >= bub) begin
        in_valid[k] = 1'b1;
        in_data[k]  = in_q[bi];
      end else begin
        in_valid[k] = 1'b0;
      end
      #1;
      chk("in_ready_rule", int'(in_ready[k]), int'(!out_valid[k] || out_ready[k]));
      if (stall > 0 && out_valid[k]) begin
        gd = $signed(out_data[k]);
        chk("stall_in_ready", int'(in_ready[k]), 0);
        if (exp_d.size() > 0) begin
          chk("stall_hold_data", gd, exp_d[0]);
          chk("stall_hold_addr", int'(out_addr[k]), exp_a[0]);
        end
        stall--;
      end
      if (out_valid[k] && out_ready[k]) begin
        if (exp_d.size() == 0) begin
          chk("extra_output", int'(out_addr[k]), -1);
        end else begin
          gd = $signed(out_data[k]);
          chk("out_data", gd, exp_d[0]);
          chk("out_addr", int'(out_addr[k]), exp_a[0]);
          chk("frame_done", int'(frame_done[k]), int'(exp_a[0] == last));
          void'(exp_d.pop_front());
          void'(exp_a.pop_front());
        end
      end else begin
        chk("frame_done_idle", int'(frame_done[k]), 0);
      end
      if (frame_done[k]) fd++;
      if (in_valid[k] && in_ready[k]) bi++;
      @(negedge clk);
      cyc++;
    end
    in_valid[k]  = 1'b0;
    out_ready[k] = 1'b1;
    if (cyc >= budget) chk("timeout", cyc, -1);
    chk("frame_done_count", fd, nfd_exp);
    #1;
    chk("drain_idle", int'(out_valid[k]), 0);
  endtask

  initial begin
    nreset = '0; in_valid = '0; out_ready = '1; in_data = '0;
    repeat (3) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      chk("rst_out_valid", int'(out_valid[k]), 0);
      chk("rst_out_data", int'(out_data[k]), 0);
      chk("rst_out_addr", int'(out_addr[k]), 0);
      chk("rst_frame_done", int'(frame_done[k]), 0);
      chk("rst_in_ready", int'(in_ready[k]), 0);
    end
    nreset = '1;
    @(negedge clk);

    gen_ramp();                     run(0, 0, 1'b0, 1'b0);
    gen_neg(1); model(1);           run(1, 0, 1'b0, 1'b0);
    foreach (exp_d[i]) chk("neg_relu0_expect", exp_d[i], -3);
    gen_neg(0); model(0);           run(0, 0, 1'b0, 1'b0);
    in_q = {};
    for (int i = 0; i < 32; i++) in_q.push_back(8'h80);
    model(1);                       run(1, 0, 1'b0, 1'b0);
    gen_ramp();                     run(0, 0, 1'b0, 1'b1);
    gen_ramp();                     run(0, 50, 1'b0, 1'b0);
    gen_rand(0, 3); model(0);       run(0, 30, 1'b1, 1'b0);
    gen_rand(1, 3); model(1);       run(1, 30, 1'b1, 1'b0);

    gen_rand(2, 2); model(2);       run(2, 0, 1'b0, 1'b0);

    gen_rand(2, 1); in_q = in_q[0:36];
    exp_d = {}; exp_a = {};         run(2, 20, 1'b0, 1'b0);
    nreset[2] = 1'b0;
    @(negedge clk);
    #1;
    chk("midrst_out_valid", int'(out_valid[2]), 0);
    chk("midrst_out_addr", int'(out_addr[2]), 0);
    chk("midrst_in_ready", int'(in_ready[2]), 0);
    nreset[2] = 1'b1;
    @(negedge clk);
    gen_rand(2, 1); model(2);       run(2, 30, 1'b1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
